// File: rtl/mips_multicycle_control.sv
// ============================================================================
// Module : mips_multicycle_control
// Brief  : Main control FSM for the multicycle MIPS datapath.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mips_multicycle_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 mem_to_reg,
    output logic                 reg_dst,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           pc_source,
    output logic [3:0]           state,
    output logic                 illegal_op,
    output logic [CNT_WIDTH-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_J     = 6'b000010;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_illegal;
    logic                   w_illegal;
    logic                   w_retire;
    logic [CNT_WIDTH-1:0]   r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_illegal;
            if (w_retire) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_illegal     = 1'b0;
        w_retire      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    C_OP_LW, C_OP_SW: w_next = S_MEMADR;
                    C_OP_RTYPE:       w_next = S_EXEC;
                    C_OP_BEQ:         w_next = S_BRANCH;
                    C_OP_J:           w_next = S_JUMP;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // Only lw/sw reach here; anything not lw is treated as the store.
                w_next    = (opcode == C_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_next    = S_FETCH;
                w_retire  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                w_next        = S_FETCH;
                w_retire      = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                w_next    = S_FETCH;
                w_retire  = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign state       = r_state;
    assign illegal_op  = r_illegal;
    assign instr_count = r_count;

endmodule

`default_nettype wire
